// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared register offsets, status bit layout and widths for the CNN result reader
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 32;

  localparam logic [1:0] CNN_RD_DATA_OFS   = 2'd0;
  localparam logic [1:0] CNN_RD_STATUS_OFS = 2'd1;

  localparam int CNN_ST_COUNT_W    = 16;
  localparam int CNN_ST_EMPTY_BIT  = 16;
  localparam int CNN_ST_FULL_BIT   = 17;
  localparam int CNN_ST_DONE_BIT   = 18;
  localparam int CNN_ST_UFLOW_BIT  = 19;
  localparam int CNN_ST_LANE_BIT   = 20;

  function automatic logic [63:0] cnn_status_word(
    input logic [CNN_ST_COUNT_W-1:0] count,
    input logic                      empty,
    input logic                      full,
    input logic                      done,
    input logic                      underflow,
    input logic                      lane
  );
    logic [63:0] w;
    w = '0;
    w[CNN_ST_COUNT_W-1:0] = count;
    w[CNN_ST_EMPTY_BIT]   = empty;
    w[CNN_ST_FULL_BIT]    = full;
    w[CNN_ST_DONE_BIT]    = done;
    w[CNN_ST_UFLOW_BIT]   = underflow;
    w[CNN_ST_LANE_BIT]    = lane;
    return w;
  endfunction

endpackage

// File: rtl/result_buffer.sv
// rtl/result_buffer.sv - DEPTH-entry circular store of packed result words with push/pop/count
module result_buffer #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [CW-1:0]    count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign head_o       = mem_q[rd_ptr_q];

  // A full store refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cnn_result_reader.sv
// rtl/cnn_result_reader.sv - packs 32-bit result stream into 64-bit words served as bus reads
// Optional interrupt output enabled by defining CNN_RD_IRQ_EN.
module cnn_result_reader
  import cnn_pkg::*;
#(
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = CNN_DATA_WIDTH,
  parameter int DEPTH          = 16
) (
  input  logic                      clkIn,
  input  logic                      rstIn,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  input  logic                      validIn,
  input  logic                      lastIn,
  output logic                      readyOut,
  input  logic                      rdEnIn,
  input  logic [BUS_ADDR_WIDTH-1:0] addrIn,
  output logic [BUS_DATA_WIDTH-1:0] rdDataOut,
  output logic                      rdAckOut
`ifdef CNN_RD_IRQ_EN
  ,
  output logic                      irqOut
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                      lane_q, lane_d;
  logic [DATA_WIDTH-1:0]     hold_q, hold_d;
  logic                      done_q, done_d;
  logic                      uflow_q, uflow_d;
  logic                      ready_q, ack_q;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                      accept, push, push_last, pop;
  logic [BUS_DATA_WIDTH-1:0] push_word, head;
  logic                      full, empty;
  logic [CW-1:0]             count, count_next;
  logic [1:0]                reg_sel;
  logic                      data_rd, status_rd;
  logic                      unused_addr;

  assign reg_sel     = addrIn[4:3];
  assign unused_addr = ^{addrIn[BUS_ADDR_WIDTH-1:5], addrIn[2:0]};
  assign data_rd     = rdEnIn && (reg_sel == CNN_RD_DATA_OFS);
  assign status_rd   = rdEnIn && (reg_sel == CNN_RD_STATUS_OFS);
  assign accept      = validIn & ready_q;
  assign pop         = data_rd & ~empty;

  // Lane 0 parks the element; a lone last element is flushed zero-padded.
  always_comb begin
    lane_d    = lane_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_word = '0;
    if (accept) begin
      if (lane_q) begin
        push      = 1'b1;
        push_last = lastIn;
        push_word = {dataIn, hold_q};
        lane_d    = 1'b0;
      end else if (lastIn) begin
        push      = 1'b1;
        push_last = 1'b1;
        push_word = {{DATA_WIDTH{1'b0}}, dataIn};
      end else begin
        hold_d = dataIn;
        lane_d = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    done_d  = done_q;
    uflow_d = uflow_q;
    if (rdEnIn) begin
      case (reg_sel)
        CNN_RD_DATA_OFS:   rdata_d = empty ? '0 : head;
        CNN_RD_STATUS_OFS: rdata_d = cnn_status_word(CNN_ST_COUNT_W'(count), empty, full,
                                                     done_q, uflow_q, lane_q);
        default:           rdata_d = '0;
      endcase
    end
    if (push && push_last)      done_d = 1'b1;
    else if (status_rd && empty) done_d = 1'b0;
    if (data_rd && empty)       uflow_d = 1'b1;
    else if (status_rd)         uflow_d = 1'b0;
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      lane_q  <= 1'b0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      uflow_q <= 1'b0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      uflow_q <= uflow_d;
      ready_q <= (count_next != CW'(DEPTH));
      ack_q   <= rdEnIn;
      rdata_q <= rdata_d;
    end
  end

  assign readyOut  = ready_q;
  assign rdAckOut  = ack_q;
  assign rdDataOut = rdata_q;

`ifdef CNN_RD_IRQ_EN
  logic irq_q;
  always_ff @(posedge clkIn) begin
    if (!rstIn) irq_q <= 1'b0;
    else        irq_q <= done_q | (count >= CW'(DEPTH / 2));
  end
  assign irqOut = irq_q;
`endif

  result_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (BUS_DATA_WIDTH)
  ) u_buf (
    .clk_i        (clkIn),
    .rstn_i       (rstIn),
    .push_i       (push),
    .push_data_i  (push_word),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .count_next_o (count_next)
  );

endmodule

// File: tb/tb_cnn_result_reader.sv
// tb/tb_cnn_result_reader.sv - scoreboard bench for cnn_result_reader with directed vectors
module tb_cnn_result_reader;

  localparam logic [63:0] ST_EMPTY = 64'h0000_0000_0001_0000;
  localparam logic [63:0] ST_FULL  = 64'h0000_0000_0002_0000;
  localparam logic [63:0] ST_DONE  = 64'h0000_0000_0004_0000;
  localparam logic [63:0] ST_UF    = 64'h0000_0000_0008_0000;
  localparam logic [63:0] ST_LANE  = 64'h0000_0000_0010_0000;
  localparam logic [31:0] A_DATA   = 32'h0000_0000;
  localparam logic [31:0] A_STAT   = 32'h0000_0008;
  localparam logic [31:0] E0       = 32'hA000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, valid, last, rden, ready, ack;
  logic [31:0] din, addr;
  logic [63:0] rdata;
`ifdef CNN_RD_IRQ_EN
  logic        irq;
`endif

  cnn_result_reader dut (
    .clkIn     (clk),
    .rstIn     (rstn),
    .dataIn    (din),
    .validIn   (valid),
    .lastIn    (last),
    .readyOut  (ready),
    .rdEnIn    (rden),
    .addrIn    (addr),
    .rdDataOut (rdata),
    .rdAckOut  (ack)
`ifdef CNN_RD_IRQ_EN
    ,
    .irqOut    (irq)
`endif
  );

  typedef struct {
    logic [63:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with data %h expected no ack", rdata);
      end else begin
        e = sb.pop_front();
        check(e.name, rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    valid = 1'b1;
    din   = d;
    last  = l;
    while (ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready %b expected 1", ready);
    end
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] e, input string name);
    rden = 1'b1;
    addr = a;
    sb.push_back('{data: e, name: name});
    tick();
    rden = 1'b0;
    check({name, "_ack"}, 64'(ack), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; valid = 1'b0; last = 1'b0; din = '0; rden = 1'b0; addr = '0;
    repeat (3) tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_ack",   64'(ack),   64'd0);
    check("rst_rdata", rdata,      64'd0);
    rstn = 1'b1;
    tick();
    check("ready_after_rst", 64'(ready), 64'd1);

    // Basic pair
    push(32'h3F80_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    rd(A_STAT, 64'd1, "pair_status");
    rd(A_DATA, 64'h4000_0000_3F80_0000, "pair_data");
    rd(A_STAT, ST_EMPTY, "pair_empty");

    // Odd count with last: zero-padded tail word and done flag
    push(32'h1111_1111, 1'b0);
    push(32'h2222_2222, 1'b0);
    push(32'h3333_3333, 1'b1);
    rd(A_STAT, ST_DONE | 64'd2, "last_status");
    rd(A_DATA, 64'h2222_2222_1111_1111, "last_data0");
    rd(A_DATA, 64'h0000_0000_3333_3333, "last_data1");
    rd(A_STAT, ST_EMPTY | ST_DONE, "done_seen");
    rd(A_STAT, ST_EMPTY, "done_cleared");

    // Underflow sticky then cleared by status read
    rd(A_DATA, 64'd0, "uf_data");
    rd(A_STAT, ST_EMPTY | ST_UF, "uf_status");
    rd(A_STAT, ST_EMPTY, "uf_cleared");

    // Fill to full with wrapped pointers
    for (int i = 0; i < 32; i++) push(E0 + 32'(i), 1'b0);
    check("full_ready_low", 64'(ready), 64'd0);
    rd(A_STAT, ST_FULL | 64'd16, "full_status");
    rd(A_DATA, {E0 + 32'd1, E0}, "full_data0");
    check("ready_after_pop", 64'(ready), 64'd1);
    rd(A_STAT, 64'd15, "count15");
    for (int k = 1; k < 16; k++)
      rd(A_DATA, {E0 + 32'(2 * k + 1), E0 + 32'(2 * k)}, $sformatf("drain%0d", k));
    rd(A_STAT, ST_EMPTY, "drained_status");

    // Reset with a pending half-word
    push(32'h0000_0055, 1'b0);
    rd(A_STAT, ST_EMPTY | ST_LANE, "lane_pending");
    rstn = 1'b0;
    tick();
    check("midrst_ready", 64'(ready), 64'd0);
    rstn = 1'b1;
    tick();
    check("midrst_ready_after", 64'(ready), 64'd1);
    rd(A_STAT, ST_EMPTY, "midrst_status");
    push(32'h0000_0066, 1'b0);
    push(32'h0000_0077, 1'b0);
    rd(A_DATA, 64'h0000_0077_0000_0066, "post_rst_data");
    rd(32'h0000_0018, 64'd0, "unmapped3");
    rd(32'h0000_0010, 64'd0, "unmapped2");
    rd(32'hFFFF_FF08, ST_EMPTY, "status_hi_addr");

`ifdef CNN_RD_IRQ_EN
    for (int i = 0; i < 16; i++) push(32'(i), 1'b0);
    tick();
    check("irq_high", 64'(irq), 64'd1);
    rd(A_DATA, 64'h0000_0001_0000_0000, "irq_data0");
    tick();
    check("irq_low", 64'(irq), 64'd0);
    for (int k = 1; k < 8; k++)
      rd(A_DATA, {32'(2 * k + 1), 32'(2 * k)}, $sformatf("irq_drain%0d", k));
`endif

    repeat (3) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_result_reader.md
Name: cnn_result_reader

Overview:
Drains the accelerator's 32-bit floating-point result stream (valid/ready, with a last marker) and packs pairs of results into 64-bit words. It buffers the words in a small circular store and serves them to the RISC-V bus as memory-mapped reads. It is the read-side counterpart of the bus write path that loads the accelerator input RAMs, so the CPU retrieves convolution outputs over the same 64-bit bus.

Parameters:
BUS_ADDR_WIDTH, 32, bus address width
BUS_DATA_WIDTH, 64, bus read data width; must equal 2*DATA_WIDTH
DATA_WIDTH, 32, result element width (FRAC_WIDTH+EXP_WIDTH)
DEPTH, 16, packed-word buffer entries; power of two, >=2

Ports:
clkIn  in  1  clock; all logic on rising edge
rstIn  in  1  reset, synchronous, active-low
dataIn  in  DATA_WIDTH  result element from accelerator stream
validIn  in  1  dataIn valid
lastIn  in  1  dataIn is final element of the result set
readyOut  out  1  reader accepts element this cycle
rdEnIn  in  1  bus read request, one-cycle pulse per access
addrIn  in  BUS_ADDR_WIDTH  bus byte address; only addrIn[4:3] decoded
rdDataOut  out  BUS_DATA_WIDTH  read data, valid when rdAckOut high
rdAckOut  out  1  read acknowledge

Behaviour:
- Reset (rstIn=0 at edge): readyOut=0, rdAckOut=0, rdDataOut=0. Buffer empty, pointers 0, lane=0, pending half discarded, done=0, underflow=0. Reset mid-stream drops all buffered data. readyOut=1 on the first cycle after release.
- Accept: transfer when validIn & readyOut. readyOut = !full, registered. No push while full, even if a pop occurs the same cycle.
- Packer, lane 0: element goes to hold[31:0] and lane becomes 1. If lastIn is set, push {32'h0, element} immediately instead and lane stays 0.
- Packer, lane 1: push {element, hold}; lane returns to 0.
- Done: set when the word carrying the lastIn element is pushed. Cleared by a STATUS read that sees the buffer empty.
- Buffer: circular store, wrPtr and rdPtr of width log2(DEPTH), wrap from DEPTH-1 to 0. Count width log2(DEPTH)+1, range 0..DEPTH. Simultaneous push and pop leaves count unchanged.
- Bus read latency: exactly 1 cycle. rdAckOut=1 in the cycle after every rdEnIn, including unmapped addresses. rdDataOut holds its value when rdAckOut=0.
- addrIn[4:3]=0, DATA: if not empty, return the head word and pop. If empty, return 0, no pop, set sticky underflow. A push landing in the same cycle as an empty-buffer read is not visible to that read.
- addrIn[4:3]=1, STATUS: [15:0] count (zero-extended), [16] empty, [17] full, [18] done, [19] underflow, [20] lane (half-word pending), others 0. Reading STATUS clears underflow.
- addrIn[4:3]=2 or 3: return 0, no side effects.
- DATA reads never pop a partially filled hold register.

Optional Feature:
Macro CNN_RD_IRQ_EN.
- Defined: adds port irqOut (out, 1), registered, reset 0. irqOut=1 while done=1 or count>=DEPTH/2. It falls the cycle after both conditions clear.
- Undefined: no irqOut port and no associated logic; status behaviour is identical.

Decomposition:
- Shared package cnn_pkg holds: register offsets CNN_RD_DATA_OFS=0 and CNN_RD_STATUS_OFS=1, status bit indices, and DATA_WIDTH default.
- One natural sub-module: result_buffer, the DEPTH x 64 circular store with push/pop/full/empty/count.
- Packer and bus decode stay in the top level.

Test Plan:
- Push 0x3F800000 then 0x40000000, then read STATUS -> count=1. Read DATA -> rdAckOut one cycle later, rdDataOut=0x40000000_3F800000. STATUS then shows empty=1.
- Push 3 elements (A, B, C with lastIn on C) -> count=2, done=1. Second DATA read returns 0x00000000_C. STATUS read on empty clears done.
- DEPTH=16, 32 elements with no reads -> full=1, readyOut=0 the cycle after the 32nd accept. One DATA read -> readyOut=1 the next cycle, count=15.
- DATA read with buffer empty -> rdDataOut=0, rdAckOut=1, underflow=1. STATUS read returns bit19=1, and the next STATUS read returns bit19=0.
- Push one element (lane=1), pull rstIn low for one cycle -> STATUS shows count=0 and lane=0, readyOut=0 during reset and 1 after. Read of addrIn[4:3]=3 -> 0 with ack.
- With CNN_RD_IRQ_EN defined, push 16 elements (8 words) -> irqOut=1. Read one word -> irqOut=0 the following cycle.
